// File: rtl/traffic_pkg.sv
// Shared types and constants for the four-approach traffic phase scheduler.
package traffic_pkg;

  typedef enum logic [2:0] {
    StClear   = 3'd0,
    StWait    = 3'd1,
    StGreen   = 3'd2,
    StRest    = 3'd3,
    StYellow  = 3'd4,
    StPreempt = 3'd5
  } phase_t;

  localparam logic [1:0] DIR_SN1 = 2'd0;
  localparam logic [1:0] DIR_SN2 = 2'd1;
  localparam logic [1:0] DIR_WE1 = 2'd2;
  localparam logic [1:0] DIR_WE2 = 2'd3;

  localparam int unsigned GREEN_MIN_DEF = 5;
  localparam int unsigned YELLOW_T_DEF  = 3;
  localparam int unsigned ALLRED_T_DEF  = 2;
  localparam int unsigned CNT_W_DEF     = 7;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } grant_t;

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Request/lamp/display bundle between the scheduler and its environment.
interface traffic_phase_scheduler_if;
  logic       TICK;
  logic [3:0] REQ;
  logic       EMG_REQ;
  logic [1:0] EMG_DIR;
  logic [3:0] GREEN;
  logic [3:0] YELLOW;
  logic       ALL_RED;
  logic [1:0] CUR_DIR;
  logic [3:0] CNT_TENS;
  logic [3:0] CNT_ONES;
  logic       EMG_ACK;

  modport master (
    output TICK, REQ, EMG_REQ, EMG_DIR,
    input  GREEN, YELLOW, ALL_RED, CUR_DIR, CNT_TENS, CNT_ONES, EMG_ACK
  );

  modport slave (
    input  TICK, REQ, EMG_REQ, EMG_DIR,
    output GREEN, YELLOW, ALL_RED, CUR_DIR, CNT_TENS, CNT_ONES, EMG_ACK
  );
endinterface

// File: rtl/bin2bcd99.sv
// Combinational binary to two-digit BCD; results are meaningful for inputs 0..99.
module bin2bcd99 (
  input  logic [6:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  always_comb begin
    tens_o = 4'(bin_i / 7'd10);
    ones_o = 4'(bin_i % 7'd10);
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Round-robin green sequencer with emergency preemption, timed yellow/all-red clearance
// and a BCD countdown of the seconds remaining in the current timed phase.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_MIN = GREEN_MIN_DEF,
  parameter int unsigned YELLOW_T  = YELLOW_T_DEF,
  parameter int unsigned ALLRED_T  = ALLRED_T_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                      CLK,
  input  logic                      RESET,
  traffic_phase_scheduler_if.slave  bus
);

  localparam logic [CNT_W-1:0] GreenLd  = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] YellowLd = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] AllredLd = CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] RemOne   = CNT_W'(1);

  // First requesting approach in cyclic order cur+1, cur+2, cur+3, cur.
  function automatic grant_t rr_pick(input logic [3:0] req, input logic [1:0] cur);
    grant_t     g;
    logic [1:0] idx;
    g.found = 1'b0;
    g.idx   = cur;
    for (int k = 3; k >= 0; k--) begin
      idx = cur + 2'(k + 1);
      if (req[idx]) begin
        g.found = 1'b1;
        g.idx   = idx;
      end
    end
    return g;
  endfunction

  phase_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       dir_q, dir_d;
  logic [3:0]       green_q, green_d;
  logic [3:0]       yellow_q, yellow_d;
  logic             all_red_q, all_red_d;
  logic             emg_ack_q, emg_ack_d;

  logic [3:0] cur_oh;
  logic       emg_own;
  logic       emg_other;
  logic       compete;
  logic       expire;
  logic       do_grant;
  grant_t     grant;

  always_comb begin
    cur_oh    = 4'b0001 << dir_q;
    emg_own   = bus.EMG_REQ && (bus.EMG_DIR == dir_q);
    emg_other = bus.EMG_REQ && (bus.EMG_DIR != dir_q);
    compete   = (|(bus.REQ & ~cur_oh)) || emg_other;
    expire    = bus.TICK && (rem_q == RemOne);
    grant     = rr_pick(bus.REQ, dir_q);
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    do_grant = 1'b0;

    case (state_q)
      StClear: begin
        if (expire) begin
          do_grant = 1'b1;
        end else if (bus.TICK) begin
          rem_d = rem_q - RemOne;
        end
      end
      StWait: do_grant = 1'b1;
      StGreen: begin
        // Emergency handling outranks a coincident expiry of the minimum green.
        if (emg_other) begin
          state_d = StYellow;
          rem_d   = YellowLd;
        end else if (emg_own) begin
          state_d = StPreempt;
          rem_d   = '0;
        end else if (expire) begin
          state_d = compete ? StYellow : StRest;
          rem_d   = compete ? YellowLd : '0;
        end else if (bus.TICK) begin
          rem_d = rem_q - RemOne;
        end
      end
      StRest: begin
        if (emg_own) begin
          state_d = StPreempt;
        end else if (compete) begin
          state_d = StYellow;
          rem_d   = YellowLd;
        end
      end
      StPreempt: begin
        if (!bus.EMG_REQ) begin
          state_d = StYellow;
          rem_d   = YellowLd;
        end
      end
      StYellow: begin
        if (expire) begin
          state_d = StClear;
          rem_d   = AllredLd;
        end else if (bus.TICK) begin
          rem_d = rem_q - RemOne;
        end
      end
      default: begin
        state_d = StClear;
        rem_d   = AllredLd;
      end
    endcase

    if (do_grant) begin
      if (bus.EMG_REQ) begin
        state_d = StPreempt;
        dir_d   = bus.EMG_DIR;
        rem_d   = '0;
      end else if (grant.found) begin
        state_d = StGreen;
        dir_d   = grant.idx;
        rem_d   = GreenLd;
      end else begin
        state_d = StWait;
        rem_d   = '0;
      end
    end
  end

  // Lamps are decoded from the next state so they change on the same edge as the phase.
  always_comb begin
    green_d   = '0;
    yellow_d  = '0;
    all_red_d = 1'b0;
    emg_ack_d = 1'b0;
    case (state_d)
      StGreen, StRest: green_d = 4'b0001 << dir_d;
      StPreempt: begin
        green_d   = 4'b0001 << dir_d;
        emg_ack_d = 1'b1;
      end
      StYellow: yellow_d = 4'b0001 << dir_d;
      default:  all_red_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= StClear;
      rem_q     <= AllredLd;
      dir_q     <= DIR_WE2;
      green_q   <= '0;
      yellow_q  <= '0;
      all_red_q <= 1'b1;
      emg_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      dir_q     <= dir_d;
      green_q   <= green_d;
      yellow_q  <= yellow_d;
      all_red_q <= all_red_d;
      emg_ack_q <= emg_ack_d;
    end
  end

  logic [3:0] tens;
  logic [3:0] ones;

  bin2bcd99 u_bcd (
    .bin_i  (7'(rem_q)),
    .tens_o (tens),
    .ones_o (ones)
  );

  assign bus.GREEN    = green_q;
  assign bus.YELLOW   = yellow_q;
  assign bus.ALL_RED  = all_red_q;
  assign bus.CUR_DIR  = dir_q;
  assign bus.EMG_ACK  = emg_ack_q;
  assign bus.CNT_TENS = tens;
  assign bus.CNT_ONES = ones;

  lamp_excl_a: assert property (@(posedge CLK) disable iff (!RESET)
    !((|green_q) && (|yellow_q)));
  lamp_onehot_a: assert property (@(posedge CLK) disable iff (!RESET)
    $onehot0(green_q) && $onehot0(yellow_q));
  all_red_a: assert property (@(posedge CLK) disable iff (!RESET)
    all_red_q == ((green_q == 4'b0) && (yellow_q == 4'b0)));

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed scenarios plus randomized traffic, checked cycle by cycle against a phase-level
// reference model of the intersection timing rules.
module tb_traffic_phase_scheduler;

  localparam int G = 5;
  localparam int Y = 3;
  localparam int A = 2;

  logic CLK;
  logic RESET;

  traffic_phase_scheduler_if bus ();

  traffic_phase_scheduler #(
    .GREEN_MIN (G),
    .YELLOW_T  (Y),
    .ALLRED_T  (A),
    .CNT_W     (7)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_per = 4;  // 0 selects random ticks

  // Reference model: phase name, seconds left on the display, approach last granted.
  string ph;
  int    left;
  int    dir;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] lamp(input int d);
    logic [3:0] v;
    v = 4'b0;
    v[d] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    ph   = "clear";
    left = A;
    dir  = 3;
  endtask

  task automatic decide(input logic [3:0] req, input logic emg, input logic [1:0] edir);
    if (emg) begin
      ph = "preempt"; dir = int'(edir); left = 0;
      return;
    end
    for (int k = 1; k <= 4; k++) begin
      int a;
      a = (dir + k) % 4;
      if (req[a]) begin
        ph = "green"; dir = a; left = G;
        return;
      end
    end
    ph = "wait"; left = 0;
  endtask

  task automatic model_step(input logic tick, input logic [3:0] req, input logic emg,
                            input logic [1:0] edir);
    bit own, other, compete;
    own     = emg && (int'(edir) == dir);
    other   = emg && (int'(edir) != dir);
    compete = ((req & ~lamp(dir)) != 4'b0) || other;
    if (ph == "clear") begin
      if (tick) begin
        if (left > 1) left--;
        else decide(req, emg, edir);
      end
    end else if (ph == "wait") begin
      decide(req, emg, edir);
    end else if (ph == "green") begin
      if (other) begin ph = "yellow"; left = Y; end
      else if (own) begin ph = "preempt"; left = 0; end
      else if (tick) begin
        if (left > 1) left--;
        else if (compete) begin ph = "yellow"; left = Y; end
        else begin ph = "rest"; left = 0; end
      end
    end else if (ph == "rest") begin
      if (own) ph = "preempt";
      else if (compete) begin ph = "yellow"; left = Y; end
    end else if (ph == "preempt") begin
      if (!emg) begin ph = "yellow"; left = Y; end
    end else if (ph == "yellow") begin
      if (tick) begin
        if (left > 1) left--;
        else begin ph = "clear"; left = A; end
      end
    end
  endtask

  task automatic check_all();
    bit lit;
    lit = (ph == "green") || (ph == "rest") || (ph == "preempt");
    chk("GREEN",    8'(bus.GREEN),    8'(lit ? lamp(dir) : 4'b0));
    chk("YELLOW",   8'(bus.YELLOW),   8'(ph == "yellow" ? lamp(dir) : 4'b0));
    chk("ALL_RED",  8'(bus.ALL_RED),  8'((ph == "clear") || (ph == "wait")));
    chk("CUR_DIR",  8'(bus.CUR_DIR),  8'(dir));
    chk("CNT_TENS", 8'(bus.CNT_TENS), 8'(left / 10));
    chk("CNT_ONES", 8'(bus.CNT_ONES), 8'(left % 10));
    chk("EMG_ACK",  8'(bus.EMG_ACK),  8'(ph == "preempt"));
  endtask

  task automatic cycle(input logic [3:0] req, input logic emg, input logic [1:0] edir);
    logic tick;
    @(negedge CLK);
    if (tick_per == 0) tick = ($urandom_range(0, 2) == 0);
    else tick = ((cyc % tick_per) == tick_per - 1);
    bus.TICK    = tick;
    bus.REQ     = req;
    bus.EMG_REQ = emg;
    bus.EMG_DIR = edir;
    @(posedge CLK);
    model_step(tick, req, emg, edir);
    cyc++;
    #1 check_all();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #1 RESET = 1'b0;
    #1 model_reset();
    check_all();
    chk("rst_allred", 8'(bus.ALL_RED), 8'd1);
    chk("rst_ones", 8'(bus.CNT_ONES), 8'(A));
    #1 RESET = 1'b1;
    cyc = 0;
  endtask

  task automatic run_until(input string target, input int want_left, input logic [3:0] req,
                           input logic emg, input logic [1:0] edir, input int budget);
    int n;
    n = 0;
    while (!(ph == target && (want_left < 0 || left == want_left)) && n < budget) begin
      cycle(req, emg, edir);
      n++;
    end
    chk({"reach_", target}, 8'(n < budget), 8'd1);
  endtask

  logic [1:0] grants[$];
  logic [3:0] prev_green;
  logic [3:0] rreq;
  logic       remg;
  logic [1:0] rdir;

  initial begin
    RESET = 1'b1;
    bus.TICK = 1'b0; bus.REQ = 4'b0; bus.EMG_REQ = 1'b0; bus.EMG_DIR = 2'd0;
    model_reset();
    do_reset();

    // Full rotation with every approach requesting, one tick per 10 clocks.
    tick_per = 10;
    prev_green = 4'b0;
    for (int i = 0; i < 450; i++) begin
      cycle(4'b1111, 1'b0, 2'd0);
      if (bus.GREEN !== 4'b0 && prev_green === 4'b0) grants.push_back(bus.CUR_DIR);
      prev_green = bus.GREEN;
    end
    chk("grant_count", 8'(grants.size() >= 5), 8'd1);
    if (grants.size() >= 5) begin
      chk("grant0", 8'(grants[0]), 8'd0);
      chk("grant1", 8'(grants[1]), 8'd1);
      chk("grant2", 8'(grants[2]), 8'd2);
      chk("grant3", 8'(grants[3]), 8'd3);
      chk("grant4", 8'(grants[4]), 8'd0);
    end

    // Lone request rests in green until another approach asks.
    tick_per = 4;
    do_reset();
    run_until("rest", -1, 4'b0100, 1'b0, 2'd0, 200);
    repeat (10) cycle(4'b0100, 1'b0, 2'd0);
    chk("rest_green", 8'(bus.GREEN), 8'(4'b0100));
    chk("rest_ones", 8'(bus.CNT_ONES), 8'd0);
    cycle(4'b0101, 1'b0, 2'd0);
    chk("rest_yellow", 8'(bus.YELLOW), 8'(4'b0100));
    run_until("green", -1, 4'b0101, 1'b0, 2'd0, 200);
    chk("rest_next", 8'(bus.GREEN), 8'(4'b0001));

    // Idle intersection waits, then grants the cycle after a request appears.
    do_reset();
    repeat (60) cycle(4'b0000, 1'b0, 2'd0);
    chk("wait_allred", 8'(bus.ALL_RED), 8'd1);
    cycle(4'b1000, 1'b0, 2'd0);
    chk("wait_grant", 8'(bus.GREEN), 8'(4'b1000));

    // Emergency for another approach truncates the minimum green.
    do_reset();
    run_until("green", 4, 4'b0001, 1'b0, 2'd0, 200);
    cycle(4'b0001, 1'b1, 2'd2);
    chk("emg_trunc", 8'(bus.YELLOW), 8'(4'b0001));
    run_until("preempt", -1, 4'b0001, 1'b1, 2'd2, 200);
    chk("emg_green", 8'(bus.GREEN), 8'(4'b0100));
    chk("emg_ack", 8'(bus.EMG_ACK), 8'd1);
    for (int i = 0; i < 20; i++) cycle(4'b0001, 1'b1, 2'($urandom_range(0, 3)));
    chk("emg_hold", 8'(bus.GREEN), 8'(4'b0100));
    cycle(4'b0001, 1'b0, 2'd0);
    chk("emg_drop", 8'(bus.YELLOW), 8'(4'b0100));
    chk("emg_dir", 8'(bus.CUR_DIR), 8'd2);

    // Emergency for the approach already green: no lamp dropout.
    do_reset();
    run_until("green", -1, 4'b0010, 1'b0, 2'd0, 200);
    cycle(4'b0010, 1'b1, 2'd1);
    chk("own_ack", 8'(bus.EMG_ACK), 8'd1);
    chk("own_green", 8'(bus.GREEN), 8'(4'b0010));
    chk("own_disp", 8'({bus.CNT_TENS, bus.CNT_ONES}), 8'h00);
    cycle(4'b0010, 1'b0, 2'd1);
    chk("own_yellow", 8'(bus.YELLOW), 8'(4'b0010));

    // Asynchronous reset in the middle of yellow.
    do_reset();
    chk("arst_yellow", 8'(bus.YELLOW), 8'd0);
    repeat (40) cycle(4'b1111, 1'b0, 2'd0);

    // Randomized traffic with occasional emergencies and jittered ticks.
    tick_per = 0;
    do_reset();
    rreq = 4'($urandom_range(0, 15));
    remg = 1'b0;
    rdir = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) rreq = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) begin
        remg = ~remg;
        rdir = 2'($urandom_range(0, 3));
      end else if (remg && $urandom_range(0, 9) == 0) begin
        rdir = 2'($urandom_range(0, 3));
      end
      cycle(rreq, remg, rdir);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Phase sequencer for the four-approach intersection (SN1, SN2, WE1, WE2).
- Grants green to one approach at a time: round-robin over vehicle-presence requests, with emergency preemption.
- Enforces minimum green, yellow and all-red clearance times.
- Drives the lamp outputs plus a two-digit BCD countdown for the seven-segment digit decoders, counting in seconds from an external one-second tick.

Parameters:
- GREEN_MIN, 5: minimum green duration in ticks; legal range 1..99.
- YELLOW_T, 3: yellow duration in ticks; legal range 1..99.
- ALLRED_T, 2: all-red clearance duration in ticks; legal range 1..99.
- CNT_W, 7: width of the remaining-time register; must hold 99.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- TICK  in  1  one-CLK strobe, once per second.
- REQ  in  4  vehicle presence; bit0=SN1, bit1=SN2, bit2=WE1, bit3=WE2; level-sensitive.
- EMG_REQ  in  1  emergency preemption request; level-sensitive.
- EMG_DIR  in  2  approach index requested by the emergency.
- GREEN  out  4  one-hot green lamp; same bit order as REQ.
- YELLOW  out  4  one-hot yellow lamp.
- ALL_RED  out  1  all approaches red.
- CUR_DIR  out  2  index of the approach last or currently granted.
- CNT_TENS  out  4  BCD tens digit of remaining seconds.
- CNT_ONES  out  4  BCD ones digit of remaining seconds.
- EMG_ACK  out  1  high while preemption green is active.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=CLEAR, rem=ALLRED_T, CUR_DIR=3.
  - GREEN=0, YELLOW=0, ALL_RED=1, EMG_ACK=0.
  - Count display shows ALLRED_T.
- Timed states: CLEAR, GREEN, YELLOW.
  - On a TICK cycle with rem>1: rem decrements.
  - On a TICK cycle with rem==1: the state expires, and the next state and its rem load on that same clock edge.
  - Each timed state therefore lasts exactly its parameter value in ticks.
  - No change on non-TICK cycles.
- Untimed states: WAIT, REST, PREEMPT. rem=0, display 00. Their exit transitions are evaluated every CLK, independent of TICK.
- CLEAR (ALL_RED=1): on expiry, run the grant decision.
- Grant decision, in priority order:
  - EMG_REQ=1 -> PREEMPT on EMG_DIR.
  - Otherwise, the first set REQ bit in cyclic order CUR_DIR+1, CUR_DIR+2, CUR_DIR+3, CUR_DIR -> GREEN on that approach, rem=GREEN_MIN.
  - Otherwise -> WAIT.
  - Every grant writes CUR_DIR.
- WAIT (ALL_RED=1): runs the grant decision every CLK. A request seen in cycle N produces GREEN from cycle N+1.
- GREEN (one GREEN bit set):
  - Competing demand = any REQ bit other than CUR_DIR set, or EMG_REQ=1 with EMG_DIR!=CUR_DIR.
  - EMG_REQ=1 with EMG_DIR!=CUR_DIR -> YELLOW on the next edge, truncating the minimum green; rem=YELLOW_T.
  - EMG_REQ=1 with EMG_DIR==CUR_DIR -> PREEMPT on the next edge, same approach; the lamp stays green without a glitch.
  - On expiry with competing demand -> YELLOW; otherwise -> REST.
- REST (green held, display 00):
  - Competing demand -> YELLOW on the next edge.
  - EMG_REQ=1 with EMG_DIR==CUR_DIR -> PREEMPT.
- PREEMPT:
  - GREEN on CUR_DIR, EMG_ACK=1.
  - EMG_DIR changes are ignored while EMG_REQ stays high.
  - EMG_REQ falling -> YELLOW on the next edge.
- YELLOW (one YELLOW bit on CUR_DIR, GREEN=0): on expiry -> CLEAR, rem=ALLRED_T.
- Simultaneous events:
  - An emergency truncation takes priority over a coincident TICK expiry.
  - A REQ bit dropping during GREEN does not shorten the minimum green.
- Output invariants:
  - GREEN and YELLOW are never both non-zero.
  - ALL_RED=1 exactly when GREEN and YELLOW are both 0.
  - At most one bit is set in each lamp vector.
- Lamp outputs and EMG_ACK are registered.
- CNT_TENS and CNT_ONES are combinational from rem: rem/10 and rem%10, for rem 0..99.
- Reset mid-operation returns all outputs to the reset values immediately (asynchronous assertion).

Decomposition:
- Shared package traffic_pkg holds:
  - phase_t state enum: CLEAR, WAIT, GREEN, REST, YELLOW, PREEMPT.
  - Approach index constants: DIR_SN1=0, DIR_SN2=1, DIR_WE1=2, DIR_WE2=3.
  - Default timing constants.
- One sub-module, bin2bcd99: combinational 7-bit binary to two BCD digits, valid for inputs 0..99.
- Round-robin selection stays inline as a function.

Test Plan:
1. Reset release with REQ=4'b1111 and a TICK every 10 CLK -> CLEAR for 2 ticks (display 02 then 01), then GREEN=4'b0001 for 5 ticks (display 05..01), YELLOW=4'b0001 for 3 ticks, then GREEN=4'b0010. The grant order continues 0, 1, 2, 3, 0.
2. Only REQ[2]=1 -> WE1 green for 5 ticks, then REST with display 00. Raise REQ[0] -> YELLOW=4'b0100 on the next CLK, then CLEAR, then GREEN=4'b0001.
3. REQ=0 after reset -> WAIT with ALL_RED=1 and display 00 indefinitely. Assert REQ[3] in cycle N -> GREEN=4'b1000 at cycle N+1.
4. SN1 green with rem=4, then assert EMG_REQ=1, EMG_DIR=2 -> YELLOW on SN1 on the next CLK, then CLEAR. GREEN=4'b0100 with EMG_ACK=1 is held until EMG_REQ drops; then YELLOW, and CUR_DIR=2.
5. EMG_REQ with EMG_DIR equal to the current green -> EMG_ACK=1 on the next CLK, GREEN unchanged with no one-cycle dropout, display 00.
6. Assert RESET=0 mid-YELLOW, asynchronously between edges -> ALL_RED=1, YELLOW=0, display 02 immediately. Sequencing restarts from CLEAR after release.
